avmm_wb_burst_bridge: RTL
=========================

Name: avmm_wb_burst_bridge

Overview:
Avalon-MM slave to Wishbone B4 master bridge. It is the parametrised successor of the fixed 32-bit single-beat avmm/wb conduits on the Qsys top level. It adds configurable data/address width, Avalon bursts mapped to Wishbone incrementing bursts, and err/rty/timeout handling. Avalon response codes are returned to the Nios side. The bridge sits between the Qsys interconnect and the Wishbone peripherals, such as the Ethernet/AVB MAC glue.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 32, byte address width.
BURST_W, 4, avs_burstcount width; maximum burst is 2^(BURST_W-1) beats.
TIMEOUT, 255, cycles stb may stay high without termination before the beat is aborted; minimum 1.
RETRY_MAX, 3, rty retries per beat before the beat is treated as an error.
CTI_EN, 1, 1 = emit cti/bte incrementing burst tags; 0 = cti fixed at 000.

Ports:
clk_clk  in  1  single clock for both sides
reset_reset  in  1  synchronous reset, active-high
avs_address  in  ADDR_W  byte address, DATA_W/8 aligned
avs_read  in  1  read command
avs_write  in  1  write command / write beat
avs_byteenable  in  DATA_W/8  byte lanes
avs_writedata  in  DATA_W  write data
avs_burstcount  in  BURST_W  beats; 0 is treated as 1
avs_waitrequest  out  1  stall
avs_readdata  out  DATA_W  read data
avs_readdatavalid  out  1  read beat valid
avs_response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR (timeout)
avs_writeresponsevalid  out  1  one pulse per completed write burst
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_W  byte address
wb_sel_o  out  DATA_W/8  byte select
wb_dat_o  out  DATA_W  write data
wb_cti_o  out  3  000 classic, 010 incrementing, 111 end-of-burst
wb_bte_o  out  2  always 00 (linear)
wb_dat_i  in  DATA_W  read data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination
wb_rty_i  in  1  retry termination
err_count  out  16  saturating count of error/timeout beats

Behaviour:
- All outputs are registered. On reset every output is 0 except avs_waitrequest, which is 1. The FSM goes to IDLE and err_count is cleared.
- Reset mid-transfer: cyc/stb drop at the next edge. Remaining beats are discarded; no readdatavalid or writeresponsevalid is issued.
- FSM states: IDLE, XFER, RETRY, WR_WAIT.
- IDLE: avs_waitrequest = 0. A command is accepted on an edge with read|write asserted; read has priority if both are asserted. The bridge latches address, burstcount, be, and the first write beat, then goes to XFER with cyc=stb=1 on the next cycle.
- XFER, per-beat termination priority: err > rty > ack > timeout.
  - ack: read beat produces readdatavalid = 1 and readdata = wb_dat_i on the next cycle, response 00.
  - err: read beat produces readdatavalid with data 0 and response 10. A write beat sets the sticky burst response to 10. err_count increments.
  - rty: go to RETRY (cyc=stb=0 for one cycle), then reissue the same beat. On the (RETRY_MAX+1)th rty the beat is handled as err instead.
  - timeout: the stall counter counts cycles with stb high and no termination; on reaching TIMEOUT the beat ends. Read returns data 0, response 11; write response goes to 11 unless already 10. err_count increments. cyc drops for one cycle.
- After each terminated beat, adr advances by DATA_W/8 and beats_left decrements.
  - Read with beats remaining: stay in XFER, next beat presented back-to-back (1 beat/cycle throughput).
  - Write with beats remaining: go to WR_WAIT with stb=0 and cyc=1. avs_waitrequest = 0 until avs_write latches the next beat, then return to XFER.
  - Last beat: go to IDLE with cyc=0. A write burst pulses avs_writeresponsevalid for one cycle with the sticky response, which is then cleared.
- CTI_EN=1: cti = 010 on every non-final beat of a multi-beat burst, 111 on the final beat, 000 for single-beat transfers.
- avs_waitrequest = 1 in XFER and RETRY.
- Address wraps modulo 2^ADDR_W.
- err_count saturates at 0xFFFF.
- Timeout and retry counters reset on each new beat.

Decomposition:
- Package avmm_wb_pkg:
  - state enum;
  - RESP_OKAY / RESP_SLVERR / RESP_DECERR;
  - CTI_CLASSIC / CTI_INCR / CTI_EOB.
- One sub-module, wb_beat_watchdog: owns the stall counter (TIMEOUT) and retry counter (RETRY_MAX), and outputs a timeout flag and a retry-exhausted flag. It is instantiated once.

Test Plan:
- Single read at 0x100, slave acks in the 2nd stb cycle -> wb_adr_o = 0x100, cti 000; readdatavalid exactly 1 cycle after ack with slave data, response 00.
- Read burst of 4 at 0x200, ack every cycle -> addresses 0x200/204/208/20C; cti 010,010,010,111; 4 consecutive readdatavalid pulses; cyc low after the 4th.
- Write burst of 3, Avalon master inserts a 2-cycle gap before beat 2 -> cyc held high, stb low during the gap; 3 acked beats; one writeresponsevalid, response 00.
- rty on 2 consecutive attempts then ack (RETRY_MAX=3) -> stb low for 1 cycle after each rty; same address reissued; response 00; err_count unchanged.
- Slave never responds (TIMEOUT=255), single read -> stb high exactly 255 cycles; readdatavalid with data 0, response 11; err_count = 1.
- err on beat 2 of a 3-beat read -> 3 readdatavalid pulses with responses 00,10,00; reset asserted mid-burst in a rerun -> cyc=0 next cycle, no further readdatavalid.

Source files
------------

// File: rtl/avmm_wb_pkg.sv
// Shared types and encodings for the Avalon-MM to Wishbone burst bridge.
package avmm_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RETRY   = 2'd2,
    ST_WR_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst write response: SLVERR dominates DECERR, which dominates OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] cur, input logic [1:0] nw);
    if (cur == RESP_SLVERR || nw == RESP_SLVERR) return RESP_SLVERR;
    if (cur == RESP_DECERR || nw == RESP_DECERR) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/avmm_wb_burst_bridge_watchdog.sv
// Per-beat stall (timeout) and retry counters for the Wishbone master side.
module wb_beat_watchdog #(
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic term,
  input  logic rty_take,
  input  logic beat_done,
  output logic timeout,
  output logic retry_exh
);

  localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RTY_W   = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic [RTY_W-1:0]   rty_q, rty_d;

  always_comb begin
    timeout   = stb && !term && (stall_q == STALL_W'(TIMEOUT - 1));
    retry_exh = (rty_q == RTY_W'(RETRY_MAX));
    stall_d   = (!stb || term || timeout) ? '0 : stall_q + STALL_W'(1);
    rty_d     = rty_q;
    if (beat_done)     rty_d = '0;
    else if (rty_take) rty_d = rty_q + RTY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      rty_q   <= '0;
    end else begin
      stall_q <= stall_d;
      rty_q   <= rty_d;
    end
  end

endmodule

// File: rtl/avmm_wb_burst_bridge.sv
// Avalon-MM slave to Wishbone B4 master bridge with incrementing bursts,
// err/rty/timeout handling and Avalon response reporting.
module avmm_wb_burst_bridge
  import avmm_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 4,
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3,
  parameter int CTI_EN    = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [BURST_W-1:0]  avs_burstcount,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic [1:0]          avs_response,
  output logic                avs_writeresponsevalid,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [2:0]          wb_cti_o,
  output logic [1:0]          wb_bte_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i,
  output logic [15:0]         err_count
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(BE_W);

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [BE_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [2:0]          cti_q, cti_d;
  logic                waitreq_q, waitreq_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdv_q, rdv_d, wrv_q, wrv_d;
  logic [1:0]          resp_q, resp_d, sticky_q, sticky_d;
  logic [15:0]         errc_q, errc_d;
  logic [BURST_W-1:0]  beats_q, beats_d, blen;
  logic                is_burst_q, is_burst_d;

  logic beat_act, t_err, t_rty, t_ack, t_to, beat_done;
  logic wd_timeout, wd_retry_exh;
  logic [1:0] beat_resp;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [2:0] cti_for(input logic [BURST_W-1:0] left, input logic burst);
    if (CTI_EN == 0 || !burst) return CTI_CLASSIC;
    return (left == BURST_W'(1)) ? CTI_EOB : CTI_INCR;
  endfunction

  wb_beat_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .RETRY_MAX (RETRY_MAX)
  ) u_watchdog (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .stb       (stb_q),
    .term      (wb_ack_i || wb_err_i || wb_rty_i),
    .rty_take  (t_rty),
    .beat_done (beat_done),
    .timeout   (wd_timeout),
    .retry_exh (wd_retry_exh)
  );

  // Termination priority: err > rty > ack > timeout; exhausted rty counts as err.
  always_comb begin
    beat_act  = (state_q == ST_XFER) && stb_q;
    t_err     = beat_act && (wb_err_i || (wb_rty_i && wd_retry_exh));
    t_rty     = beat_act && !wb_err_i && wb_rty_i && !wd_retry_exh;
    t_ack     = beat_act && !wb_err_i && !wb_rty_i && wb_ack_i;
    t_to      = beat_act && !wb_err_i && !wb_rty_i && !wb_ack_i && wd_timeout;
    beat_done = t_ack || t_err || t_to;
    beat_resp = t_err ? RESP_SLVERR : (t_to ? RESP_DECERR : RESP_OKAY);
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    cti_d      = cti_q;
    waitreq_d  = waitreq_q;
    rdata_d    = rdata_q;
    rdv_d      = 1'b0;
    wrv_d      = 1'b0;
    resp_d     = resp_q;
    sticky_d   = sticky_q;
    errc_d     = errc_q;
    beats_d    = beats_q;
    is_burst_d = is_burst_q;
    blen       = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;

    case (state_q)
      ST_IDLE: begin
        waitreq_d = 1'b0;
        if ((avs_read || avs_write) && !waitreq_q) begin
          beats_d    = blen;
          is_burst_d = (blen != BURST_W'(1));
          adr_d      = avs_address;
          sel_d      = avs_byteenable;
          wdat_d     = avs_writedata;
          we_d       = !avs_read;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          waitreq_d  = 1'b1;
          cti_d      = cti_for(blen, blen != BURST_W'(1));
          sticky_d   = RESP_OKAY;
          state_d    = ST_XFER;
        end
      end

      ST_XFER: begin
        if (t_rty) begin
          state_d = ST_RETRY;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
        end else if (beat_done) begin
          if (!we_q) begin
            rdv_d   = 1'b1;
            rdata_d = t_ack ? wb_dat_i : '0;
            resp_d  = beat_resp;
          end
          if (t_err || t_to) errc_d = sat_inc(errc_q);
          adr_d   = adr_q + ADR_STEP;
          beats_d = beats_q - BURST_W'(1);
          cti_d   = cti_for(beats_q - BURST_W'(1), is_burst_q);
          if (beats_q == BURST_W'(1)) begin
            state_d   = ST_IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            waitreq_d = 1'b0;
            cti_d     = CTI_CLASSIC;
            if (we_q) begin
              wrv_d  = 1'b1;
              resp_d = resp_merge(sticky_q, beat_resp);
            end
            sticky_d = RESP_OKAY;
          end else if (we_q) begin
            // Hold the bus between write beats unless the beat timed out.
            state_d   = ST_WR_WAIT;
            stb_d     = 1'b0;
            cyc_d     = !t_to;
            waitreq_d = 1'b0;
            sticky_d  = resp_merge(sticky_q, beat_resp);
          end else if (t_to) begin
            state_d = ST_RETRY;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end
        end
      end

      ST_RETRY: begin
        state_d = ST_XFER;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
      end

      ST_WR_WAIT: begin
        cyc_d     = 1'b1;
        waitreq_d = 1'b0;
        if (avs_write && !waitreq_q) begin
          wdat_d    = avs_writedata;
          sel_d     = avs_byteenable;
          stb_d     = 1'b1;
          waitreq_d = 1'b1;
          state_d   = ST_XFER;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      wdat_q     <= '0;
      cti_q      <= CTI_CLASSIC;
      waitreq_q  <= 1'b1;
      rdata_q    <= '0;
      rdv_q      <= 1'b0;
      wrv_q      <= 1'b0;
      resp_q     <= RESP_OKAY;
      sticky_q   <= RESP_OKAY;
      errc_q     <= '0;
      beats_q    <= '0;
      is_burst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      cti_q      <= cti_d;
      waitreq_q  <= waitreq_d;
      rdata_q    <= rdata_d;
      rdv_q      <= rdv_d;
      wrv_q      <= wrv_d;
      resp_q     <= resp_d;
      sticky_q   <= sticky_d;
      errc_q     <= errc_d;
      beats_q    <= beats_d;
      is_burst_q <= is_burst_d;
    end
  end

  assign avs_waitrequest        = waitreq_q;
  assign avs_readdata           = rdata_q;
  assign avs_readdatavalid      = rdv_q;
  assign avs_response           = resp_q;
  assign avs_writeresponsevalid = wrv_q;
  assign wb_cyc_o               = cyc_q;
  assign wb_stb_o               = stb_q;
  assign wb_we_o                = we_q;
  assign wb_adr_o               = adr_q;
  assign wb_sel_o               = sel_q;
  assign wb_dat_o               = wdat_q;
  assign wb_cti_o               = cti_q;
  assign wb_bte_o               = 2'b00;
  assign err_count              = errc_q;

endmodule
